// File: rtl/heepsilon_pkg.sv
// Shared constants and types for the HEEPsilon external-bus scratchpad responder.
package heepsilon_pkg;

  localparam logic [31:0] OBI_OOB_PATTERN      = 32'hBADCAB1E;
  localparam int unsigned SCRATCHPAD_NUM_WORDS = 256;
  localparam int unsigned GNT_WAIT_MAX         = 15;
  localparam int unsigned RSP_LATENCY_MIN      = 1;
  localparam int unsigned RSP_LATENCY_MAX      = 4;
  localparam int unsigned GNT_CNT_W            = $clog2(GNT_WAIT_MAX + 1);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } gnt_state_e;

endpackage

// File: rtl/obi_pkg.sv
// OBI bus request/response types shared by managers and responders on the external crossbar.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/heepsilon_rsp_delay.sv
// Fixed-depth response delay line: {valid, rdata} advances one stage per clock.
module heepsilon_rsp_delay #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic [31:0] rdata_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic        busy_o
);

  logic [LATENCY-1:0]       vld_q, vld_d;
  logic [LATENCY-1:0][31:0] data_q, data_d;

  // Idle slots carry zero data so rdata reads 0 whenever rvalid is low.
  always_comb begin
    vld_d     = '0;
    data_d    = '0;
    vld_d[0]  = push_i;
    data_d[0] = push_i ? rdata_i : 32'h0;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign valid_o = vld_q[LATENCY-1];
  assign rdata_o = data_q[LATENCY-1];
  assign busy_o  = |vld_q;

endmodule

// File: rtl/heepsilon_obi_scratchpad.sv
// OBI responder backed by a byte-maskable word scratchpad, with programmable
// grant wait-states and response latency for bus latency injection.
module heepsilon_obi_scratchpad
  import heepsilon_pkg::*;
  import obi_pkg::*;
#(
  parameter int unsigned NUM_WORDS   = SCRATCHPAD_NUM_WORDS,
  parameter int unsigned GNT_WAIT    = 0,
  parameter int unsigned RSP_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  obi_req_t    req_i,
  output obi_resp_t   resp_o,
  output logic [15:0] oob_count_o,
  output logic        busy_o
);

  localparam int unsigned AW = $clog2(NUM_WORDS);
  localparam logic [GNT_CNT_W-1:0] CNT_INIT = GNT_CNT_W'((GNT_WAIT == 0) ? 0 : GNT_WAIT - 1);

  logic [31:0]          mem_q [NUM_WORDS];
  gnt_state_e           state_q, state_d;
  logic [GNT_CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]          oob_count_q, oob_count_d;
  logic                 gnt, acc, oob;
  logic [AW-1:0]        idx;
  logic [31:0]          wmerge, rdata_push;
  logic                 dly_valid, dly_busy;
  logic [31:0]          dly_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i.req) begin
          if (GNT_WAIT == 0) begin
            gnt = 1'b1;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // A dropped request abandons the transaction without any access.
        if (!req_i.req) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          gnt     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Nothing is granted (and nothing committed) while reset is held.
    if (rst_i) gnt = 1'b0;
  end

  always_comb begin
    idx    = req_i.addr[2 +: AW];
    oob    = |(req_i.addr >> (2 + AW));
    acc    = req_i.req & gnt;
    wmerge = mem_q[idx];
    for (int i = 0; i < 4; i++) begin
      if (req_i.be[i]) wmerge[8*i +: 8] = req_i.wdata[8*i +: 8];
    end
    rdata_push = req_i.we ? 32'h0 : (oob ? OBI_OOB_PATTERN : mem_q[idx]);
    oob_count_d = oob_count_q;
    if (acc && oob && (oob_count_q != 16'hFFFF)) oob_count_d = oob_count_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      oob_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      oob_count_q <= oob_count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (acc && req_i.we && !oob) mem_q[idx] <= wmerge;
  end

  heepsilon_rsp_delay #(
    .LATENCY (RSP_LATENCY)
  ) u_rsp_delay (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (acc),
    .rdata_i (rdata_push),
    .valid_o (dly_valid),
    .rdata_o (dly_rdata),
    .busy_o  (dly_busy)
  );

  always_comb begin
    resp_o        = '0;
    resp_o.gnt    = gnt;
    resp_o.rvalid = dly_valid;
    resp_o.rdata  = dly_rdata;
  end

  assign oob_count_o = oob_count_q;
  assign busy_o      = (state_q == ST_WAIT) || dly_busy;

endmodule

// File: tb/tb_heepsilon_obi_scratchpad.sv
// Directed bench for heepsilon_obi_scratchpad across three wait/latency configurations.
module tb_heepsilon_obi_scratchpad;
  import obi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  obi_req_t    req0, req1, req2;
  obi_resp_t   rsp0, rsp1, rsp2;
  logic [15:0] oob0, oob1, oob2;
  logic        busy0, busy1, busy2;
  int          total = 0;
  int          bad = 0;
  logic [31:0] pat [8] = '{32'h0101_1010, 32'h0202_2020, 32'h0303_3030, 32'h0404_4040,
                           32'h0505_5050, 32'h0606_6060, 32'h0707_7070, 32'h0808_8080};

  always #5 clk = ~clk;

  heepsilon_obi_scratchpad #(.NUM_WORDS(256), .GNT_WAIT(0), .RSP_LATENCY(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req0), .resp_o(rsp0), .oob_count_o(oob0), .busy_o(busy0));
  heepsilon_obi_scratchpad #(.NUM_WORDS(256), .GNT_WAIT(3), .RSP_LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .resp_o(rsp1), .oob_count_o(oob1), .busy_o(busy1));
  heepsilon_obi_scratchpad #(.NUM_WORDS(256), .GNT_WAIT(0), .RSP_LATENCY(4)) dut2 (
    .clk_i(clk), .rst_i(rst), .req_i(req2), .resp_o(rsp2), .oob_count_o(oob2), .busy_o(busy2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int which, input logic r, input logic we, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] d);
    obi_req_t t;
    t.req = r; t.we = we; t.be = be; t.addr = a; t.wdata = d;
    case (which)
      0:       req0 = t;
      1:       req1 = t;
      default: req2 = t;
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 4'h0, 0, 0); drive(1, 0, 0, 4'h0, 0, 0); drive(2, 0, 0, 4'h0, 0, 0);
    repeat (3) step();
    @(negedge clk);
    total++; if (rsp0 !== '0) begin bad++; $display("FAIL rst_resp0: got %h want 0", rsp0); end
    total++; if (rsp1 !== '0) begin bad++; $display("FAIL rst_resp1: got %h want 0", rsp1); end
    total++; if (rsp2 !== '0) begin bad++; $display("FAIL rst_resp2: got %h want 0", rsp2); end
    total++; if (oob0 !== 16'h0) begin bad++; $display("FAIL rst_oob0: got %h want 0", oob0); end
    total++; if (oob2 !== 16'h0) begin bad++; $display("FAIL rst_oob2: got %h want 0", oob2); end
    total++; if ({busy0, busy1, busy2} !== 3'b000) begin bad++; $display("FAIL rst_busy: got %b want 000", {busy0, busy1, busy2}); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    step(); drive(0, 1, 1, 4'hF, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    total++; if (rsp0.gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt_wr: got %b want 1", rsp0.gnt); end
    total++; if (rsp0.rvalid !== 1'b0) begin bad++; $display("FAIL b2b_rv_c0: got %b want 0", rsp0.rvalid); end
    step(); drive(0, 1, 0, 4'hF, 32'h10, 32'h0);
    @(negedge clk);
    total++; if (rsp0.gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt_rd: got %b want 1", rsp0.gnt); end
    total++; if (rsp0.rvalid !== 1'b1) begin bad++; $display("FAIL b2b_rv_c1: got %b want 1", rsp0.rvalid); end
    total++; if (rsp0.rdata !== 32'h0) begin bad++; $display("FAIL b2b_wr_rdata: got %h want 0", rsp0.rdata); end
    step(); drive(0, 0, 0, 4'h0, 0, 0);
    @(negedge clk);
    total++; if (rsp0.rvalid !== 1'b1) begin bad++; $display("FAIL b2b_rv_c2: got %b want 1", rsp0.rvalid); end
    total++; if (rsp0.rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_raw: got %h want deadbeef", rsp0.rdata); end
    total++; if (rsp0.gnt !== 1'b0) begin bad++; $display("FAIL b2b_gnt_idle: got %b want 0", rsp0.gnt); end
    step();
    @(negedge clk);
    total++; if (rsp0.rvalid !== 1'b0) begin bad++; $display("FAIL b2b_rv_c3: got %b want 0", rsp0.rvalid); end
  endtask

  task automatic test_byte_enables();
    step(); drive(0, 1, 1, 4'b0101, 32'h10, 32'h11223344);
    step(); drive(0, 1, 0, 4'hF, 32'h10, 32'h0);
    step(); drive(0, 0, 0, 4'h0, 0, 0);
    @(negedge clk);
    total++; if (rsp0.rdata !== 32'hDE22BE44) begin bad++; $display("FAIL be_0101: got %h want de22be44", rsp0.rdata); end
    step(); drive(0, 1, 1, 4'b0000, 32'h10, 32'hFFFFFFFF);
    step(); drive(0, 0, 0, 4'h0, 0, 0);
    @(negedge clk);
    total++; if (rsp0.rvalid !== 1'b1) begin bad++; $display("FAIL be_0000_rsp: got %b want 1", rsp0.rvalid); end
    step(); drive(0, 1, 0, 4'hF, 32'h10, 32'h0);
    step(); drive(0, 0, 0, 4'h0, 0, 0);
    @(negedge clk);
    total++; if (rsp0.rdata !== 32'hDE22BE44) begin bad++; $display("FAIL be_0000_keep: got %h want de22be44", rsp0.rdata); end
  endtask

  task automatic test_gnt_wait();
    step(); drive(1, 1, 1, 4'hF, 32'h20, 32'hCAFEF00D);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) step();
      @(negedge clk);
      total++; if (rsp1.gnt !== (c == 4)) begin bad++; $display("FAIL wait_gnt_c%0d: got %b want %b", c, rsp1.gnt, c == 4); end
      total++; if (busy1 !== (c >= 2)) begin bad++; $display("FAIL wait_busy_c%0d: got %b want %b", c, busy1, c >= 2); end
    end
    step(); drive(1, 0, 0, 4'h0, 0, 0);
    @(negedge clk);
    total++; if ({rsp1.rvalid, busy1} !== 2'b11) begin bad++; $display("FAIL wait_rv_busy: got %b want 11", {rsp1.rvalid, busy1}); end
    step();
    @(negedge clk);
    total++; if ({rsp1.rvalid, busy1} !== 2'b00) begin bad++; $display("FAIL wait_done: got %b want 00", {rsp1.rvalid, busy1}); end
    step(); drive(1, 1, 0, 4'hF, 32'h20, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) step();
      @(negedge clk);
      total++; if (rsp1.gnt !== (c == 4)) begin bad++; $display("FAIL wait_rd_gnt_c%0d: got %b want %b", c, rsp1.gnt, c == 4); end
    end
    step(); drive(1, 0, 0, 4'h0, 0, 0);
    @(negedge clk);
    total++; if (rsp1.rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL wait_rdata: got %h want cafef00d", rsp1.rdata); end
  endtask

  task automatic test_gnt_drop();
    step(); drive(1, 1, 0, 4'hF, 32'h20, 32'h0);
    @(negedge clk);
    total++; if (rsp1.gnt !== 1'b0) begin bad++; $display("FAIL drop_gnt_c1: got %b want 0", rsp1.gnt); end
    step();
    @(negedge clk);
    total++; if (rsp1.gnt !== 1'b0) begin bad++; $display("FAIL drop_gnt_c2: got %b want 0", rsp1.gnt); end
    step(); drive(1, 0, 0, 4'h0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      step();
      @(negedge clk);
      total++; if ({rsp1.gnt, rsp1.rvalid, busy1} !== 3'b000) begin bad++; $display("FAIL drop_idle_c%0d: got %b want 000", c, {rsp1.gnt, rsp1.rvalid, busy1}); end
    end
    step(); drive(1, 1, 0, 4'hF, 32'h20, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) step();
      @(negedge clk);
      total++; if (rsp1.gnt !== (c == 4)) begin bad++; $display("FAIL drop_regnt_c%0d: got %b want %b", c, rsp1.gnt, c == 4); end
    end
    step(); drive(1, 0, 0, 4'h0, 0, 0);
  endtask

  task automatic test_out_of_range();
    step(); drive(0, 1, 1, 4'hF, 32'h0, 32'h0A0B0C0D);
    step(); drive(0, 1, 0, 4'hF, 32'h400, 32'h0);
    @(negedge clk);
    total++; if (rsp0.gnt !== 1'b1) begin bad++; $display("FAIL oob_rd_gnt: got %b want 1", rsp0.gnt); end
    total++; if (oob0 !== 16'd0) begin bad++; $display("FAIL oob_cnt0: got %0d want 0", oob0); end
    step(); drive(0, 1, 1, 4'hF, 32'h800, 32'hFFFFFFFF);
    @(negedge clk);
    total++; if (rsp0.rdata !== 32'hBADCAB1E) begin bad++; $display("FAIL oob_rdata: got %h want badcab1e", rsp0.rdata); end
    total++; if (oob0 !== 16'd1) begin bad++; $display("FAIL oob_cnt1: got %0d want 1", oob0); end
    step(); drive(0, 1, 0, 4'hF, 32'h0, 32'h0);
    @(negedge clk);
    total++; if (oob0 !== 16'd2) begin bad++; $display("FAIL oob_cnt2: got %0d want 2", oob0); end
    step(); drive(0, 0, 0, 4'h0, 0, 0);
    @(negedge clk);
    total++; if (rsp0.rdata !== 32'h0A0B0C0D) begin bad++; $display("FAIL oob_wr_drop: got %h want 0a0b0c0d", rsp0.rdata); end
    total++; if (oob0 !== 16'd2) begin bad++; $display("FAIL oob_cnt_hold: got %0d want 2", oob0); end
  endtask

  task automatic test_oob_saturate();
    step(); drive(0, 1, 0, 4'hF, 32'h400, 32'h0);
    repeat (65532) @(posedge clk);
    #1 drive(0, 0, 0, 4'h0, 0, 0);
    @(negedge clk);
    total++; if (oob0 !== 16'hFFFE) begin bad++; $display("FAIL sat_fffe: got %h want fffe", oob0); end
    step(); drive(0, 1, 0, 4'hF, 32'h400, 32'h0);
    repeat (5) @(posedge clk);
    #1 drive(0, 0, 0, 4'h0, 0, 0);
    @(negedge clk);
    total++; if (oob0 !== 16'hFFFF) begin bad++; $display("FAIL sat_ffff: got %h want ffff", oob0); end
    total++; if (rsp0.rdata !== 32'hBADCAB1E) begin bad++; $display("FAIL sat_rdata: got %h want badcab1e", rsp0.rdata); end
  endtask

  task automatic test_latency();
    for (int i = 0; i < 8; i++) begin
      step(); drive(2, 1, 1, 4'hF, 32'(i * 4), pat[i]);
    end
    step(); drive(2, 0, 0, 4'h0, 0, 0);
    repeat (5) step();
    for (int k = 0; k < 12; k++) begin
      step();
      if (k < 8) drive(2, 1, 0, 4'hF, 32'(k * 4), 32'h0);
      else       drive(2, 0, 0, 4'h0, 0, 0);
      @(negedge clk);
      if (k < 8) begin
        total++; if (rsp2.gnt !== 1'b1) begin bad++; $display("FAIL lat_gnt_k%0d: got %b want 1", k, rsp2.gnt); end
      end
      total++; if (rsp2.rvalid !== (k >= 4)) begin bad++; $display("FAIL lat_rv_k%0d: got %b want %b", k, rsp2.rvalid, k >= 4); end
      if (k >= 4) begin
        total++; if (rsp2.rdata !== pat[k-4]) begin bad++; $display("FAIL lat_rdata_k%0d: got %h want %h", k, rsp2.rdata, pat[k-4]); end
      end
    end
    step();
    @(negedge clk);
    total++; if (rsp2.rvalid !== 1'b0) begin bad++; $display("FAIL lat_tail: got %b want 0", rsp2.rvalid); end
  endtask

  task automatic test_reset_inflight();
    for (int k = 0; k < 3; k++) begin
      step(); drive(2, 1, 0, 4'hF, 32'(k * 4), 32'h0);
    end
    step();
    drive(2, 0, 0, 4'h0, 0, 0);
    drive(0, 1, 1, 4'hF, 32'h10, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    total++; if ({busy2, rsp2.rvalid} !== 2'b10) begin bad++; $display("FAIL rif_inflight: got %b want 10", {busy2, rsp2.rvalid}); end
    total++; if (rsp0.gnt !== 1'b0) begin bad++; $display("FAIL rif_gnt_in_rst: got %b want 0", rsp0.gnt); end
    step();
    @(negedge clk);
    total++; if ({busy2, rsp2.rvalid} !== 2'b00) begin bad++; $display("FAIL rif_cleared: got %b want 00", {busy2, rsp2.rvalid}); end
    step();
    rst = 1'b0;
    drive(0, 0, 0, 4'h0, 0, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++; if (rsp2.rvalid !== 1'b0) begin bad++; $display("FAIL rif_rv_c%0d: got %b want 0", c, rsp2.rvalid); end
      step();
    end
    drive(0, 1, 0, 4'hF, 32'h10, 32'h0);
    step(); drive(0, 0, 0, 4'h0, 0, 0);
    @(negedge clk);
    total++; if (rsp0.rdata !== 32'hDE22BE44) begin bad++; $display("FAIL rif_no_commit: got %h want de22be44", rsp0.rdata); end
  endtask

  initial begin
    req0 = '0; req1 = '0; req2 = '0;
    test_reset();
    test_back_to_back();
    test_byte_enables();
    test_gnt_wait();
    test_gnt_drop();
    test_out_of_range();
    test_oob_saturate();
    test_latency();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
